// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array output path.
package systolic_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH
    } drain_state_t;

endpackage

// File: rtl/systolic_drain_row_fifo.sv
// Synchronous FIFO for aligned rows; a push while full is accepted only alongside a pop.
module row_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// Deskews bottom-row partial sums into aligned rows, buffers them and tracks drain jobs.
module systolic_drain #(
    parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 2,
    parameter int unsigned DATA_WIDTH           = systolic_pkg::DEFAULT_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH           = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] sys_data_out_in,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]            sys_valid_out_in,
    input  logic [15:0]                                ub_rd_col_size_in,
    input  logic                                       ub_rd_col_size_valid_in,
    input  logic [15:0]                                drain_rows_in,
    input  logic                                       drain_start_in,
    output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] row_data_out,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0]            row_mask_out,
    output logic                                       row_valid_out,
    input  logic                                       row_ready_in,
    output logic                                       busy_out,
    output logic                                       done_out,
    output logic                                       overflow_out,
    output logic                                       skew_err_out
);

    import systolic_pkg::*;

    localparam int unsigned N       = SYSTOLIC_ARRAY_WIDTH;
    localparam int unsigned ROW_W   = N * DATA_WIDTH;
    localparam int unsigned ENTRY_W = ROW_W + N;
    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;

    logic [N-1:0] col_mask_q, col_mask_d;

    always_comb begin
        col_mask_d = col_mask_q;
        if (ub_rd_col_size_valid_in) begin
            for (int j = 0; j < N; j++) begin
                col_mask_d[j] = ({16'd0, ub_rd_col_size_in} > 32'(j));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_mask_q <= '0;
        end else begin
            col_mask_q <= col_mask_d;
        end
    end

    logic [N-1:0][DATA_WIDTH-1:0] al_data;
    logic [N-1:0]                 al_valid;

    // Column j lags column 0 by j cycles, so it needs N-1-j stages to line up with column N-1.
    for (genvar j = 0; j < N; j++) begin : g_col
        localparam int unsigned STAGES = N - 1 - j;
        if (STAGES == 0) begin : g_pass
            assign al_data[j]  = sys_data_out_in[j*DATA_WIDTH +: DATA_WIDTH];
            assign al_valid[j] = sys_valid_out_in[j];
        end else begin : g_dly
            logic [STAGES-1:0][DATA_WIDTH-1:0] d_q;
            logic [STAGES-1:0]                 v_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    d_q <= '0;
                    v_q <= '0;
                end else begin
                    d_q[0] <= sys_data_out_in[j*DATA_WIDTH +: DATA_WIDTH];
                    v_q[0] <= sys_valid_out_in[j];
                    for (int k = 1; k < STAGES; k++) begin
                        d_q[k] <= d_q[k-1];
                        v_q[k] <= v_q[k-1];
                    end
                end
            end

            assign al_data[j]  = d_q[STAGES-1];
            assign al_valid[j] = v_q[STAGES-1];
        end
    end

    logic             row_hit, row_skew;
    logic [ROW_W-1:0] row_data;

    always_comb begin
        row_hit  = |(al_valid & col_mask_q);
        row_skew = row_hit && ((al_valid & col_mask_q) != col_mask_q);
        row_data = '0;
        for (int j = 0; j < N; j++) begin
            if (col_mask_q[j]) begin
                row_data[j*DATA_WIDTH +: DATA_WIDTH] = al_data[j];
            end
        end
    end

    logic               fifo_push, fifo_full, fifo_empty, pop_fire, drain_last;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CW-1:0]      fifo_count;

    assign pop_fire   = row_valid_out && row_ready_in;
    // True when the FIFO will be empty at the next edge (no pushes happen in FLUSH).
    assign drain_last = fifo_empty || ((fifo_count == CW'(1)) && pop_fire);

    row_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({col_mask_q, row_data}),
        .pop       (pop_fire),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    drain_state_t state_q, state_d;
    logic [15:0]  rows_seen_q, rows_seen_d;
    logic [15:0]  target_q, target_d;
    logic         overflow_q, overflow_d;
    logic         skew_q, skew_d;
    logic         done_q, done_d;

    always_comb begin
        state_d     = state_q;
        rows_seen_d = rows_seen_q;
        target_d    = target_q;
        overflow_d  = overflow_q;
        skew_d      = skew_q;
        done_d      = 1'b0;
        fifo_push   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (drain_start_in) begin
                    if (drain_rows_in != 16'd0) begin
                        state_d     = ACTIVE;
                        rows_seen_d = '0;
                        overflow_d  = 1'b0;
                        skew_d      = 1'b0;
                        target_d    = drain_rows_in;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (row_hit) begin
                    fifo_push   = 1'b1;
                    rows_seen_d = rows_seen_q + 16'd1;
                    if (row_skew) begin
                        skew_d = 1'b1;
                    end
                    if (fifo_full && !pop_fire) begin
                        overflow_d = 1'b1;
                    end
                    if (rows_seen_d == target_q) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (drain_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rows_seen_q <= '0;
            target_q    <= '0;
            overflow_q  <= 1'b0;
            skew_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_seen_q <= rows_seen_d;
            target_q    <= target_d;
            overflow_q  <= overflow_d;
            skew_q      <= skew_d;
            done_q      <= done_d;
        end
    end

    assign row_valid_out = !fifo_empty;
    assign row_data_out  = row_valid_out ? fifo_head[ROW_W-1:0] : '0;
    assign row_mask_out  = row_valid_out ? fifo_head[ENTRY_W-1:ROW_W] : '0;
    assign busy_out      = (state_q != IDLE);
    assign done_out      = done_q;
    assign overflow_out  = overflow_q;
    assign skew_err_out  = skew_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain with N=2: directed jobs, expected rows queued at issue.
module tb_systolic_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sys_data;
    logic [1:0]  sys_valid;
    logic [15:0] col_size;
    logic        col_size_valid;
    logic [15:0] drain_rows;
    logic        drain_start;
    logic [31:0] row_data;
    logic [1:0]  row_mask;
    logic        row_valid;
    logic        row_ready;
    logic        busy, done, overflow, skew_err;

    systolic_drain #(
        .SYSTOLIC_ARRAY_WIDTH (2),
        .DATA_WIDTH           (16),
        .FIFO_DEPTH           (4)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .sys_data_out_in         (sys_data),
        .sys_valid_out_in        (sys_valid),
        .ub_rd_col_size_in       (col_size),
        .ub_rd_col_size_valid_in (col_size_valid),
        .drain_rows_in           (drain_rows),
        .drain_start_in          (drain_start),
        .row_data_out            (row_data),
        .row_mask_out            (row_mask),
        .row_valid_out           (row_valid),
        .row_ready_in            (row_ready),
        .busy_out                (busy),
        .done_out                (done),
        .overflow_out            (overflow),
        .skew_err_out            (skew_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  mask;
        int          cyc;   // -1: any cycle
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (row_valid && row_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_row: got data %h mask %b, expected no row", row_data,
                             row_mask);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (row_data !== mon_e.data || row_mask !== mon_e.mask ||
                        (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
                        n_err++;
                        $display("FAIL row: got data %h mask %b cyc %0d, expected data %h mask %b cyc %0d",
                                 row_data, row_mask, cyc, mon_e.data, mon_e.mask, mon_e.cyc);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                n_vec++;
                if (row_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_with_row: got row_valid %b, expected 0", row_valid);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cols(input logic v0, input logic [15:0] d0, input logic v1,
                            input logic [15:0] d1);
        sys_valid = {v1, v0};
        sys_data  = {d1, d0};
    endtask

    task automatic expect_row(input logic [31:0] data, input logic [1:0] mask, input int c);
        exp_t e;
        e.data = data;
        e.mask = mask;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic load_cols(input logic [15:0] size);
        col_size       = size;
        col_size_valid = 1'b1;
        tick();
        col_size_valid = 1'b0;
    endtask

    task automatic start_job(input logic [15:0] rows);
        drain_rows  = rows;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
    endtask

    // Row k: column 0 = b0+k+1 in cycle k, column 1 = b1+k+1 in cycle k+1.
    task automatic send_rows(input int n, input logic [15:0] b0, input logic [15:0] b1);
        for (int i = 0; i <= n; i++) begin
            set_cols(i < n, (i < n) ? b0 + 16'(i + 1) : 16'd0,
                     i >= 1, (i >= 1) ? b1 + 16'(i) : 16'd0);
            tick();
        end
        set_cols(1'b0, 16'd0, 1'b0, 16'd0);
    endtask

    task automatic wait_done(input int prev, input int bound, input string name);
        int i = 0;
        while (done_cnt == prev && i < bound) begin
            @(negedge clk);
            i++;
        end
        n_vec++;
        if (done_cnt == prev) begin
            n_err++;
            $display("FAIL %s: got no done_out within %0d cycles, expected a pulse", name, bound);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected the run to end");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int dc;
        rst            = 1'b1;
        sys_data       = '0;
        sys_valid      = '0;
        col_size       = '0;
        col_size_valid = 1'b0;
        drain_rows     = '0;
        drain_start    = 1'b0;
        row_ready      = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_row_valid", row_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", {overflow, skew_err}, 0);
        check("rst_row", {row_mask, row_data}, 0);
        tick();
        rst = 1'b0;
        tick();

        // 1. Basic job: exact latency of both rows and of done
        load_cols(16'd2);
        dc = done_cnt;
        start_job(16'd2);
        t0 = cyc;
        check("t1_busy", busy, 1);
        expect_row({16'd9, 16'd5}, 2'b11, t0 + 2);
        expect_row({16'd3, 16'd7}, 2'b11, t0 + 3);
        set_cols(1'b1, 16'd5, 1'b0, 16'd0);
        tick();
        set_cols(1'b1, 16'd7, 1'b1, 16'd9);
        tick();
        set_cols(1'b0, 16'd0, 1'b1, 16'd3);
        tick();
        set_cols(1'b0, 16'd0, 1'b0, 16'd0);
        wait_done(dc, 20, "t1_done");
        check("t1_done_cycle", last_done_cyc, t0 + 4);

        // 2. Backpressure: fifth row dropped
        tick();
        row_ready = 1'b0;
        dc = done_cnt;
        start_job(16'd5);
        for (int k = 0; k < 4; k++) begin
            expect_row({16'h1000 + 16'(k + 1), 16'h0100 + 16'(k + 1)}, 2'b11, -1);
        end
        send_rows(5, 16'h0100, 16'h1000);
        tick();
        tick();
        check("t2_overflow", overflow, 1);
        check("t2_row_valid", row_valid, 1);
        check("t2_busy", busy, 1);
        check("t2_no_early_done", done_cnt, dc);
        row_ready = 1'b1;
        wait_done(dc, 20, "t2_done");
        tick();
        check("t2_idle", busy, 0);

        // 4. Skew error: column 1 arrives in the same cycle as column 0
        dc = done_cnt;
        start_job(16'd2);
        check("t4_overflow_cleared", overflow, 0);
        check("t4_skew_clear", skew_err, 0);
        t0 = cyc;
        expect_row({16'h0022, 16'h0000}, 2'b11, t0 + 1);
        expect_row({16'h0000, 16'h0011}, 2'b11, t0 + 2);
        set_cols(1'b1, 16'h0011, 1'b1, 16'h0022);
        tick();
        set_cols(1'b0, 16'd0, 1'b0, 16'd0);
        wait_done(dc, 20, "t4_done");
        check("t4_done_cycle", last_done_cyc, t0 + 3);
        check("t4_skew_set", skew_err, 1);
        tick();
        tick();
        tick();
        check("t4_skew_sticky", skew_err, 1);

        // 3. Single column: disabled column reads 0
        load_cols(16'd1);
        dc = done_cnt;
        start_job(16'd1);
        check("t3_skew_cleared", skew_err, 0);
        t0 = cyc;
        expect_row({16'h0000, 16'h1234}, 2'b01, t0 + 2);
        set_cols(1'b1, 16'h1234, 1'b0, 16'hBEEF);
        tick();
        set_cols(1'b0, 16'd0, 1'b0, 16'hBEEF);
        tick();
        set_cols(1'b0, 16'd0, 1'b0, 16'd0);
        wait_done(dc, 20, "t3_done");
        tick();

        // 5. Reset mid-job with two rows buffered
        row_ready = 1'b0;
        dc = done_cnt;
        start_job(16'd4);
        send_rows(2, 16'h0200, 16'h2000);
        tick();
        check("t5_buffered", row_valid, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_row_valid", row_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        tick();
        tick();
        rst = 1'b0;
        row_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("t5_no_done", done_cnt, dc);
        check("t5_still_empty", row_valid, 0);

        // 6. Zero-row job
        dc = done_cnt;
        t0 = cyc;
        drain_rows  = 16'd0;
        drain_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t6_busy_low", busy, 0);
            tick();
            drain_start = 1'b0;
        end
        check("t6_done_count", done_cnt, dc + 1);
        check("t6_done_cycle", last_done_cyc, t0 + 1);

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
